// File: rtl/instruction_mem_arbiter.sv
// instruction_mem_arbiter: shares one instruction-memory cacheline port
// between NumRequesters instruction caches. Round-robin grant, lock while
// memory backpressures, and an in-order tag FIFO that steers each memory
// response back to the cache that issued the request.
// Optional build macro: INSTRUCTION_MEM_ARBITER_PERF_EN adds per-requester
// stall counters (stall_cnt_o) and a FIFO high-water mark (max_outstanding_o).
module instruction_mem_arbiter #(
  parameter int NumRequesters      = 4,
  parameter int CachelineAddrWidth = 7,
  parameter int CachelineWidth     = 128,
  parameter int MaxOutstanding     = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NumRequesters-1:0]                    ic_req_i,
  output logic [NumRequesters-1:0]                    ic_ready_o,
  input  logic [NumRequesters*CachelineAddrWidth-1:0] ic_addr_i,
  output logic [NumRequesters-1:0]                    ic_valid_o,
  output logic [CachelineWidth-1:0]                   ic_data_o,
  output logic                                        mem_req_o,
  input  logic                                        mem_ready_i,
  output logic [CachelineAddrWidth-1:0]               mem_addr_o,
  input  logic                                        mem_valid_i,
  input  logic [CachelineWidth-1:0]                   mem_data_i
`ifdef INSTRUCTION_MEM_ARBITER_PERF_EN
  ,
  output logic [NumRequesters*32-1:0]                 stall_cnt_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]         max_outstanding_o
`endif
);

  localparam int TagW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
  localparam logic [TagW-1:0] TagLast = TagW'(NumRequesters - 1);

  // Tag FIFO storage and bookkeeping
  logic [TagW-1:0] tag_mem_reg [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_reg;
  logic [PtrW-1:0] rd_ptr_reg;
  logic [CntW-1:0] count_reg;
  logic [CntW-1:0] count_next;

  // Arbiter state
  logic [TagW-1:0] rr_ptr_reg;
  logic [TagW-1:0] rr_ptr_next;
  logic            lock_reg;
  logic [TagW-1:0] lock_idx_reg;

  // Response registers
  logic [NumRequesters-1:0]  valid_reg;
  logic [CachelineWidth-1:0] data_reg;

  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          any_req;
  logic                          handshake;
  logic                          pop;
  logic [TagW-1:0]               search_idx;
  logic [TagW-1:0]               grant_idx;
  logic [TagW-1:0]               head_tag;
  logic [NumRequesters-1:0]      head_onehot;
  logic [CachelineAddrWidth-1:0] addr_slice [NumRequesters];

  assign fifo_full  = (count_reg == CntMax);
  assign fifo_empty = (count_reg == '0);
  assign any_req    = |ic_req_i;
  assign mem_req_o  = any_req && !fifo_full;
  assign handshake  = mem_req_o && mem_ready_i;
  assign pop        = mem_valid_i && !fifo_empty;
  assign head_tag   = tag_mem_reg[rd_ptr_reg];
  assign grant_idx  = lock_reg ? lock_idx_reg : search_idx;
  assign mem_addr_o = addr_slice[grant_idx];
  assign ic_valid_o = valid_reg;
  assign ic_data_o  = data_reg;

  // Per-requester address slices, ready decode and response one-hot decode
  generate
    for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_req
      assign addr_slice[gi]  = ic_addr_i[gi*CachelineAddrWidth +: CachelineAddrWidth];
      assign ic_ready_o[gi]  = mem_ready_i && !fifo_full && ic_req_i[gi] &&
                               (grant_idx == TagW'(gi));
      assign head_onehot[gi] = (head_tag == TagW'(gi));
    end
  endgenerate

  // Round-robin search: first requester at or after rr_ptr, wrapping
  always_comb begin
    logic [TagW-1:0] cand;
    logic            found;
    search_idx = rr_ptr_reg;
    cand       = rr_ptr_reg;
    found      = 1'b0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (!found && ic_req_i[cand]) begin
        found      = 1'b1;
        search_idx = cand;
      end
      cand = (cand == TagLast) ? '0 : cand + TagW'(1);
    end
  end

  // Next-state values for the FIFO occupancy and the round-robin pointer
  always_comb begin
    count_next = count_reg;
    if (handshake && !pop) begin
      count_next = count_reg + CntW'(1);
    end else if (!handshake && pop) begin
      count_next = count_reg - CntW'(1);
    end
    rr_ptr_next = (grant_idx == TagLast) ? '0 : grant_idx + TagW'(1);
  end

  // Tag storage: the accepted requester's index is written at the tail
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      tag_mem_reg[wr_ptr_reg] <= grant_idx;
    end
  end

  // FIFO pointers and occupancy; a same-cycle pop frees space only next cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (handshake) begin
        wr_ptr_reg <= (wr_ptr_reg == PtrLast) ? '0 : wr_ptr_reg + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PtrLast) ? '0 : rd_ptr_reg + PtrW'(1);
      end
      count_reg <= count_next;
    end
  end

  // Arbiter state: advance past the winner on handshake, lock while stalled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg   <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else if (handshake) begin
      rr_ptr_reg <= rr_ptr_next;
      lock_reg   <= 1'b0;
    end else if (mem_req_o) begin
      lock_reg     <= 1'b1;
      lock_idx_reg <= grant_idx;
    end
  end

  // Response path: route popped tag one cycle later, data holds otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg <= '0;
      data_reg  <= '0;
    end else if (pop) begin
      valid_reg <= head_onehot;
      data_reg  <= mem_data_i;
    end else begin
      valid_reg <= '0;
    end
  end

`ifdef INSTRUCTION_MEM_ARBITER_PERF_EN
  logic [CntW-1:0] max_out_reg;

  generate
    for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_stall
      logic [31:0] stall_cnt_reg;
      // Saturating count of cycles this requester waits without acceptance
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          stall_cnt_reg <= '0;
        end else if (ic_req_i[gi] && !ic_ready_o[gi] && (stall_cnt_reg != '1)) begin
          stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
      end
      assign stall_cnt_o[gi*32 +: 32] = stall_cnt_reg;
    end
  endgenerate

  // High-water mark of the registered FIFO occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      max_out_reg <= '0;
    end else if (count_reg > max_out_reg) begin
      max_out_reg <= count_reg;
    end
  end

  assign max_outstanding_o = max_out_reg;
`endif

`ifndef SYNTHESIS
  a_no_resp_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_valid_i |-> !fifo_empty);
  a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_req_o && !mem_ready_i) |=> (mem_req_o && $stable(mem_addr_o)));
  a_valid_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(ic_valid_o));
`endif

endmodule
